// File: rtl/score_keeper.sv
// Pong score sequencer: counts rally points, sequences IDLE/SERVE/PLAY/OVER
// and drives lamp masks, ball enable and serve direction for the pong datapath.
module score_keeper #(
  parameter int unsigned WIN_POINTS   = 5,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       p1_score,
  input  logic       p2_score,
  output logic [2:0] p1_points,
  output logic [2:0] p2_points,
  output logic [4:0] p1_mask,
  output logic [4:0] p2_mask,
  output logic       ball_enable,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_PLAY  = 2'd2,
    S_OVER  = 2'd3
  } state_e;

  localparam logic [2:0] WIN        = 3'(WIN_POINTS);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] p1_q, p1_d;
  logic [2:0] p2_q, p2_d;
  logic       dir_q, dir_d;
  logic       winner_q, winner_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    dir_d    = dir_q;
    winner_d = winner_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SERVE;
          cnt_d   = '0;
          p1_d    = '0;
          p2_d    = '0;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          if (cnt_q == SERVE_LAST) begin
            state_d = S_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_PLAY: begin
        // Simultaneous pulses are a tie and are dropped; points saturate at WIN.
        if (p1_score && !p2_score) begin
          p1_d  = (p1_q < WIN) ? p1_q + 3'd1 : p1_q;
          dir_d = 1'b1;
          if (p1_d == WIN) begin
            state_d  = S_OVER;
            winner_d = 1'b0;
          end else begin
            state_d = S_SERVE;
          end
        end else if (p2_score && !p1_score) begin
          p2_d  = (p2_q < WIN) ? p2_q + 3'd1 : p2_q;
          dir_d = 1'b0;
          if (p2_d == WIN) begin
            state_d  = S_OVER;
            winner_d = 1'b1;
          end else begin
            state_d = S_SERVE;
          end
        end
      end
      S_OVER: begin
        if (start) begin
          state_d  = S_SERVE;
          cnt_d    = '0;
          p1_d     = '0;
          p2_d     = '0;
          dir_d    = 1'b0;
          winner_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      dir_q    <= 1'b0;
      winner_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      dir_q    <= dir_d;
      winner_q <= winner_d;
    end
  end

  always_comb begin
    p1_mask = '0;
    p2_mask = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (i < WIN_POINTS) begin
        p1_mask[i] = ({29'd0, p1_q} > i);
        p2_mask[i] = ({29'd0, p2_q} > i);
      end
    end
  end

  assign p1_points   = p1_q;
  assign p2_points   = p2_q;
  assign ball_enable = (state_q == S_PLAY);
  assign game_over   = (state_q == S_OVER);
  assign serve_dir   = dir_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: a reference model pushes expected outputs
// per driven cycle; they are popped and asserted one cycle later.
module tb_score_keeper;
  localparam int unsigned WP = 5;
  localparam int unsigned SF = 60;

  logic       clk = 1'b0;
  logic       rst, start, frame_tick, p1_score, p2_score;
  logic [2:0] p1_points, p2_points;
  logic [4:0] p1_mask, p2_mask;
  logic       ball_enable, serve_dir, game_over, winner;

  always #5 clk = ~clk;

  score_keeper #(.WIN_POINTS(WP), .SERVE_FRAMES(SF)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick),
    .p1_score(p1_score), .p2_score(p2_score),
    .p1_points(p1_points), .p2_points(p2_points),
    .p1_mask(p1_mask), .p2_mask(p2_mask),
    .ball_enable(ball_enable), .serve_dir(serve_dir),
    .game_over(game_over), .winner(winner)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [19:0] exp_q[$];

  // Reference model: 0 idle, 1 serve, 2 play, 3 over
  int          m_state = 0;
  int unsigned m_cnt   = 0;
  logic [2:0]  m_p1 = '0, m_p2 = '0;
  logic        m_dir = 1'b0, m_win = 1'b0;

  function automatic logic [4:0] lamp(input logic [2:0] p);
    logic [5:0] t, w;
    t = (6'd1 << p) - 6'd1;
    w = (6'd1 << WP) - 6'd1;
    return t[4:0] & w[4:0];
  endfunction

  function automatic logic [19:0] model_out();
    return {m_p1, m_p2, lamp(m_p1), lamp(m_p2), (m_state == 2), m_dir, (m_state == 3), m_win};
  endfunction

  function automatic logic [19:0] dut_out();
    return {p1_points, p2_points, p1_mask, p2_mask, ball_enable, serve_dir, game_over, winner};
  endfunction

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, st, tk, s1, s2);
    if (r) begin
      m_state = 0; m_cnt = 0; m_p1 = '0; m_p2 = '0; m_dir = 1'b0; m_win = 1'b0;
    end else begin
      case (m_state)
        0: if (st) begin m_state = 1; m_cnt = 0; m_p1 = '0; m_p2 = '0; end
        1: if (tk) begin
             if (m_cnt == SF - 1) begin m_state = 2; m_cnt = 0; end
             else m_cnt = m_cnt + 1;
           end
        2: if (s1 != s2) begin
             if (s1) begin
               if (m_p1 != 3'(WP)) m_p1 = m_p1 + 3'd1;
               m_dir = 1'b1;
               if (m_p1 == 3'(WP)) begin m_state = 3; m_win = 1'b0; end else m_state = 1;
             end else begin
               if (m_p2 != 3'(WP)) m_p2 = m_p2 + 3'd1;
               m_dir = 1'b0;
               if (m_p2 == 3'(WP)) begin m_state = 3; m_win = 1'b1; end else m_state = 1;
             end
           end
        default: if (st) begin
             m_state = 1; m_cnt = 0; m_p1 = '0; m_p2 = '0; m_dir = 1'b0; m_win = 1'b0;
           end
      endcase
    end
  endtask

  task automatic step(input string tag, input logic r, st, tk, s1, s2);
    rst = r; start = st; frame_tick = tk; p1_score = s1; p2_score = s2;
    model_update(r, st, tk, s1, s2);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; frame_tick = 1'b0; p1_score = 1'b0; p2_score = 1'b0;
    check(tag, dut_out(), exp_q.pop_front());
  endtask

  // Full serve delay; optionally pulses start mid-serve (must be ignored).
  task automatic serve(input logic poke_start);
    for (int i = 0; i < int'(SF); i++) begin
      step("serve_tick", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (i == int'(SF) - 2) check("be_low_after_59", 20'(ball_enable), 20'd0);
      if (i < int'(SF) - 1)
        step("serve_gap", 1'b0, poke_start && (i == 10), 1'b0, 1'b0, 1'b0);
    end
    check("be_high_after_60", 20'(ball_enable), 20'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; frame_tick = 1'b0; p1_score = 1'b0; p2_score = 1'b0;
    step("reset0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("reset1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_outputs", dut_out(), 20'd0);
    step("idle_tick", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("serve_be_low", 20'(ball_enable), 20'd0);
    serve(1'b1);
    check("p1_mask_zero", 20'(p1_mask), 20'd0);
    step("tick_in_play", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      step("p1_point", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("be_drop_on_score", 20'(ball_enable), 20'd0);
      serve(1'b0);
    end
    check("p1_points_3", 20'(p1_points), 20'd3);
    check("p1_mask_3", 20'(p1_mask), 20'b00111);
    check("serve_dir_1", 20'(serve_dir), 20'd1);
    check("p2_points_0", 20'(p2_points), 20'd0);

    step("both_scores", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("both_be", 20'(ball_enable), 20'd1);
    check("both_pts", 20'({p1_points, p2_points}), 20'({3'd3, 3'd0}));

    step("p2_point", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("p1_in_serve", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("serve_score_ignored", 20'(p1_points), 20'd3);
    serve(1'b0);
    for (int k = 2; k <= 5; k++) begin
      step("p2_point", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (k < 5) serve(1'b0);
    end
    check("over_flag", 20'({game_over, winner, ball_enable}), 20'b110);
    check("p2_mask_full", 20'(p2_mask), 20'b11111);
    step("p2_in_over", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("p1_in_over", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("saturate", 20'({p1_points, p2_points}), 20'({3'd3, 3'd5}));

    step("restart", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_clear", dut_out(), 20'd0);
    serve(1'b0);
    step("r_p1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); serve(1'b0);
    step("r_p2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); serve(1'b0);
    step("r_p1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); serve(1'b0);
    step("r_p2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); serve(1'b0);
    step("r_p2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); serve(1'b0);
    check("score_2_3", 20'({p1_points, p2_points, p2_mask}), 20'({3'd2, 3'd3, 5'b00111}));
    step("mid_reset", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("mid_reset_outputs", dut_out(), 20'd0);
    step("post_reset_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("queue_drained", 20'(exp_q.size()), 20'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
